// File: rtl/bike_pkg.sv
// ----------------------------------------------------------------------------
// bike_pkg
// Shared types and helpers for the bike grid sequencer.
//   - dir_t / DIR_* : 2-bit heading encoding (right, up = y-1, left, down = y+1)
//   - state_t       : sequencer FSM states
//   - pos_t         : wide {x, y} coordinate pair used by next_pos
//   - opposite()    : the heading that would be a 180 degree turn
//   - next_pos()    : one step in a direction; callers truncate to their
//                     coordinate width, which gives modulo-2^LOG_GRID wrap
// ----------------------------------------------------------------------------
package bike_pkg;

    localparam int COORD_W = 16;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [1:0]         dir_t;

    localparam dir_t DIR_RIGHT = 2'b00;
    localparam dir_t DIR_UP    = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_DOWN  = 2'b11;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pos_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READY,
        ST_P1_MARK,
        ST_P2_MARK,
        ST_P1_READ,
        ST_P1_CHK,
        ST_P2_READ,
        ST_P2_CHK,
        ST_RESOLVE,
        ST_OVER
    } state_t;

    // Right<->left and up<->down differ only in bit 1.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

    function automatic pos_t next_pos(input coord_t x, input coord_t y, input dir_t d);
        pos_t p;
        p.x = x;
        p.y = y;
        case (d)
            DIR_RIGHT: p.x = x + coord_t'(1);
            DIR_UP:    p.y = y - coord_t'(1);
            DIR_LEFT:  p.x = x - coord_t'(1);
            default:   p.y = y + coord_t'(1);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/grid_port_arb.sv
// ----------------------------------------------------------------------------
// grid_port_arb
// Shares the single grid RAM port between the VGA reader and the sequencer.
// VGA always wins its cycle; the sequencer sees stall and holds its access.
//   clk, reset            : clock, synchronous active-high reset
//   vga_req, vga_addr     : VGA read request and {y,x} address
//   seq_addr/we/wdata     : sequencer's pending access for this cycle
//   mem_rdata             : RAM read data (1-cycle latency)
//   mem_addr/we/wdata     : muxed RAM port
//   stall                 : sequencer lost the port this cycle
//   vga_rvalid, vga_rdata : VGA read response, one cycle after the grant
// ----------------------------------------------------------------------------
module grid_port_arb
    import bike_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    input  logic [AW-1:0] seq_addr,
    input  logic          seq_we,
    input  logic          seq_wdata,
    input  logic          mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_wdata,
    output logic          stall,
    output logic          vga_rvalid,
    output logic          vga_rdata
);

    logic vld_q;

    assign stall     = vga_req;
    assign mem_addr  = vga_req ? vga_addr : seq_addr;
    // A VGA-granted cycle never carries a write.
    assign mem_we    = seq_we    & ~vga_req;
    assign mem_wdata = seq_wdata & ~vga_req;

    always_ff @(posedge clk) begin
        if (reset) vld_q <= 1'b0;
        else       vld_q <= vga_req;
    end

    assign vga_rvalid = vld_q;
    // Gated so the data output reads 0 whenever no response is presented.
    assign vga_rdata  = vld_q & mem_rdata;

endmodule

// File: rtl/bike_grid_sequencer.sv
// ----------------------------------------------------------------------------
// bike_grid_sequencer
// Game-step controller owning the trail-grid RAM port. Clears the grid on
// start, then on each tick marks both heads, reads both next cells, and
// resolves crashes. VGA reads are interleaved with priority.
// Build option: GRID_WRAP_EN -- CLEAR writes 0 everywhere (no border walls).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, tick             : round start / game step pulses
//   dir_p1, dir_p2          : requested headings
//   vga_req, vga_x, vga_y   : VGA cell read request
//   vga_rdata, vga_rvalid   : VGA read response
//   mem_addr/we/wdata/rdata : grid RAM port, address {y,x}
//   p1_x, p1_y, p2_x, p2_y  : bike heads
//   crash                   : {P2, P1} crash flags, sticky for the round
//   busy, round_over        : status
// ----------------------------------------------------------------------------
module bike_grid_sequencer
    import bike_pkg::*;
#(
    parameter int GRID_SIZE  = 32,
    parameter int LOG_GRID   = 5,
    parameter int P1_START_X = 8,
    parameter int P1_START_Y = 16,
    parameter int P2_START_X = 23,
    parameter int P2_START_Y = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  tick,
    input  logic [1:0]            dir_p1,
    input  logic [1:0]            dir_p2,
    input  logic                  vga_req,
    input  logic [LOG_GRID-1:0]   vga_x,
    input  logic [LOG_GRID-1:0]   vga_y,
    output logic                  vga_rdata,
    output logic                  vga_rvalid,
    output logic [2*LOG_GRID-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_wdata,
    input  logic                  mem_rdata,
    output logic [LOG_GRID-1:0]   p1_x,
    output logic [LOG_GRID-1:0]   p1_y,
    output logic [LOG_GRID-1:0]   p2_x,
    output logic [LOG_GRID-1:0]   p2_y,
    output logic [1:0]            crash,
    output logic                  busy,
    output logic                  round_over
);

    localparam int AW = 2*LOG_GRID;
    localparam logic [LOG_GRID-1:0] EDGE = LOG_GRID'(GRID_SIZE-1);

    state_t              state, state_nx;
    dir_t                dir1, dir2;
    logic [AW-1:0]       clr_addr;
    logic                cand1, cand2;
    logic                rd_fresh;
    logic                stall;
    logic [AW-1:0]       seq_addr;
    logic                seq_we, seq_wdata;
    pos_t                n1, n2;
    logic [LOG_GRID-1:0] nx1, ny1, nx2, ny2;
    logic [LOG_GRID-1:0] clr_x, clr_y;
    logic                clr_border, clr_last, same;
    logic [1:0]          crash_nx;

    grid_port_arb #(.AW(AW)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .vga_req    (vga_req),
        .vga_addr   ({vga_y, vga_x}),
        .seq_addr   (seq_addr),
        .seq_we     (seq_we),
        .seq_wdata  (seq_wdata),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata)
    );

    // Next heads; truncation to LOG_GRID bits is the modulo wrap.
    always_comb begin
        n1  = next_pos(coord_t'(p1_x), coord_t'(p1_y), dir1);
        n2  = next_pos(coord_t'(p2_x), coord_t'(p2_y), dir2);
        nx1 = n1.x[LOG_GRID-1:0];
        ny1 = n1.y[LOG_GRID-1:0];
        nx2 = n2.x[LOG_GRID-1:0];
        ny2 = n2.y[LOG_GRID-1:0];
    end

    assign same     = (nx1 == nx2) && (ny1 == ny2);
    assign crash_nx = crash | {cand2, cand1} | {2{same}};

    assign clr_x      = clr_addr[LOG_GRID-1:0];
    assign clr_y      = clr_addr[AW-1:LOG_GRID];
    assign clr_last   = (clr_addr == '1);
`ifdef GRID_WRAP_EN
    assign clr_border = 1'b0;
`else
    assign clr_border = (clr_x == '0) || (clr_x == EDGE) ||
                        (clr_y == '0) || (clr_y == EDGE);
`endif

    assign busy       = !(state == ST_IDLE || state == ST_READY || state == ST_OVER);
    assign round_over = (state == ST_OVER);

    always_comb begin
        state_nx  = state;
        seq_addr  = '0;
        seq_we    = 1'b0;
        seq_wdata = 1'b0;
        case (state)
            ST_IDLE, ST_OVER: if (start) state_nx = ST_CLEAR;
            ST_CLEAR: begin
                seq_addr  = clr_addr;
                seq_we    = 1'b1;
                seq_wdata = clr_border;
                if (!stall && clr_last) state_nx = ST_READY;
            end
            ST_READY: if (tick) state_nx = ST_P1_MARK;
            ST_P1_MARK: begin
                seq_addr  = {p1_y, p1_x};
                seq_we    = 1'b1;
                seq_wdata = 1'b1;
                if (!stall) state_nx = ST_P2_MARK;
            end
            ST_P2_MARK: begin
                seq_addr  = {p2_y, p2_x};
                seq_we    = 1'b1;
                seq_wdata = 1'b1;
                if (!stall) state_nx = ST_P1_READ;
            end
            ST_P1_READ: begin
                seq_addr = {ny1, nx1};
                if (!stall) state_nx = ST_P1_CHK;
            end
            ST_P1_CHK: if (!stall) state_nx = ST_P2_READ;
            ST_P2_READ: begin
                seq_addr = {ny2, nx2};
                if (!stall) state_nx = ST_P2_CHK;
            end
            ST_P2_CHK: if (!stall) state_nx = ST_RESOLVE;
            ST_RESOLVE: if (!stall) state_nx = (crash_nx != 2'b00) ? ST_OVER : ST_READY;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            p1_x     <= LOG_GRID'(P1_START_X);
            p1_y     <= LOG_GRID'(P1_START_Y);
            p2_x     <= LOG_GRID'(P2_START_X);
            p2_y     <= LOG_GRID'(P2_START_Y);
            dir1     <= DIR_RIGHT;
            dir2     <= DIR_LEFT;
            crash    <= 2'b00;
            clr_addr <= '0;
            cand1    <= 1'b0;
            cand2    <= 1'b0;
            rd_fresh <= 1'b0;
        end else begin
            state <= state_nx;
            // mem_rdata is valid only in the first cycle after a granted read;
            // a stalled CHK cycle would otherwise see VGA data instead.
            rd_fresh <= !stall && (state == ST_P1_READ || state == ST_P2_READ);
            case (state)
                ST_IDLE, ST_OVER: if (start) begin
                    clr_addr <= '0;
                    crash    <= 2'b00;
                end
                ST_CLEAR: if (!stall) begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_last) begin
                        p1_x  <= LOG_GRID'(P1_START_X);
                        p1_y  <= LOG_GRID'(P1_START_Y);
                        p2_x  <= LOG_GRID'(P2_START_X);
                        p2_y  <= LOG_GRID'(P2_START_Y);
                        dir1  <= DIR_RIGHT;
                        dir2  <= DIR_LEFT;
                        crash <= 2'b00;
                    end
                end
                ST_READY: if (tick) begin
                    if (dir_p1 != opposite(dir1)) dir1 <= dir_p1;
                    if (dir_p2 != opposite(dir2)) dir2 <= dir_p2;
                end
                ST_P1_CHK: if (rd_fresh) cand1 <= mem_rdata;
                ST_P2_CHK: if (rd_fresh) cand2 <= mem_rdata;
                ST_RESOLVE: if (!stall) begin
                    p1_x  <= nx1;
                    p1_y  <= ny1;
                    p2_x  <= nx2;
                    p2_y  <= ny2;
                    crash <= crash_nx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bike_grid_sequencer.sv
// ----------------------------------------------------------------------------
// Bench for bike_grid_sequencer: behavioural RAM, a game-level reference
// model (cell array + head positions), and a scoreboard monitor that checks
// every completed step (busy falling) and every VGA read response.
// ----------------------------------------------------------------------------
module tb_bike_grid_sequencer;

    localparam int LG = 5;
    localparam int GS = 32;

    logic          clk = 1'b0;
    logic          reset, start, tick, vga_req;
    logic [1:0]    dir_p1, dir_p2;
    logic [LG-1:0] vga_x, vga_y;
    logic          vga_rdata, vga_rvalid;
    logic [2*LG-1:0] mem_addr;
    logic          mem_we, mem_wdata;
    logic          mem_rdata;
    logic [LG-1:0] p1_x, p1_y, p2_x, p2_y;
    logic [1:0]    crash;
    logic          busy, round_over;

    always #5 clk = ~clk;

    bike_grid_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .dir_p1(dir_p1), .dir_p2(dir_p2),
        .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .crash(crash), .busy(busy), .round_over(round_over)
    );

    // Grid RAM: synchronous write, registered read.
    logic ram [0:GS*GS-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int p1x, p1y, p2x, p2y, crash, over, lat;
    } exp_t;

    exp_t     sq[$];
    bit       vq[$];
    bit       grid [0:GS-1][0:GS-1];
    int       m1x, m1y, m2x, m2y;
    bit [1:0] md1, md2;
    bit       mover;
    int       vga_issued = 0;
    int       rv_seen    = 0;

    task automatic push_state(input int c, input int lat);
        exp_t e;
        e.p1x = m1x; e.p1y = m1y; e.p2x = m2x; e.p2y = m2y;
        e.crash = c; e.over = mover; e.lat = lat;
        sq.push_back(e);
    endtask

    task automatic model_clear();
        for (int y = 0; y < GS; y++)
            for (int x = 0; x < GS; x++)
`ifdef GRID_WRAP_EN
                grid[y][x] = 1'b0;
`else
                grid[y][x] = (x == 0 || x == GS-1 || y == 0 || y == GS-1);
`endif
        m1x = 8;  m1y = 16; m2x = 23; m2y = 16;
        md1 = 2'b00; md2 = 2'b10; mover = 1'b0;
        push_state(0, GS*GS);
    endtask

    task automatic step(input int x, input int y, input bit [1:0] d, output int nx, output int ny);
        nx = x; ny = y;
        case (d)
            2'b00: nx = (x + 1) % GS;
            2'b01: ny = (y + GS - 1) % GS;
            2'b10: nx = (x + GS - 1) % GS;
            default: ny = (y + 1) % GS;
        endcase
    endtask

    task automatic model_tick(input bit [1:0] d1, input bit [1:0] d2, input int lat);
        int n1x, n1y, n2x, n2y;
        bit c1, c2;
        if (d1 != (md1 ^ 2'b10)) md1 = d1;
        if (d2 != (md2 ^ 2'b10)) md2 = d2;
        grid[m1y][m1x] = 1'b1;
        grid[m2y][m2x] = 1'b1;
        step(m1x, m1y, md1, n1x, n1y);
        step(m2x, m2y, md2, n2x, n2y);
        c1 = grid[n1y][n1x];
        c2 = grid[n2y][n2x];
        if (n1x == n2x && n1y == n2y) begin c1 = 1'b1; c2 = 1'b1; end
        m1x = n1x; m1y = n1y; m2x = n2x; m2y = n2y;
        mover = c1 | c2;
        push_state({30'd0, c2, c1}, lat);
    endtask

    // ---------------- monitor ----------------
    initial begin
        int  busy_cnt;
        bit  prev_busy;
        bit  b;
        exp_t e;
        busy_cnt = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
                prev_busy = 1'b0;
            end else begin
                if (vga_rvalid) begin
                    rv_seen++;
                    if (vq.size() == 0) chk("vga_unexpected", 1, 0);
                    else begin
                        b = vq.pop_front();
                        chk("vga_rdata", int'(vga_rdata), int'(b));
                    end
                end
                if (busy) busy_cnt++;
                else if (prev_busy) begin
                    if (sq.size() == 0) chk("step_unexpected", 1, 0);
                    else begin
                        e = sq.pop_front();
                        chk("p1_x", int'(p1_x), e.p1x);
                        chk("p1_y", int'(p1_y), e.p1y);
                        chk("p2_x", int'(p2_x), e.p2x);
                        chk("p2_y", int'(p2_y), e.p2y);
                        chk("crash", int'(crash), e.crash);
                        chk("round_over", int'(round_over), e.over);
                        chk("busy_cycles", busy_cnt, e.lat);
                    end
                    busy_cnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("busy_timeout", 1, 0);
    endtask

    task automatic do_start(input bit with_tick);
        @(posedge clk); #1;
        start = 1'b1; tick = with_tick;
        @(posedge clk); #1;
        start = 1'b0; tick = 1'b0;
        model_clear();
        wait_idle();
    endtask

    task automatic vga_read(input int x, input int y);
        @(posedge clk); #1;
        vga_req = 1'b1; vga_x = LG'(x); vga_y = LG'(y);
        vq.push_back(grid[y][x]);
        vga_issued++;
        @(posedge clk); #1;
        vga_req = 1'b0;
    endtask

    // stall_n > 0: hold vga_req that many cycles mid-step.
    // drop: issue a second tick while busy, which must be ignored.
    task automatic do_tick(input bit [1:0] d1, input bit [1:0] d2, input int stall_n, input bit drop);
        @(posedge clk); #1;
        dir_p1 = d1; dir_p2 = d2; tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        model_tick(d1, d2, 7 + stall_n);
        if (drop) begin
            @(posedge clk); #1;
            tick = 1'b1; dir_p1 = 2'b01; dir_p2 = 2'b01;
            @(posedge clk); #1;
            tick = 1'b0;
        end
        if (stall_n > 0) begin
            @(posedge clk); #1;
            for (int i = 0; i < stall_n; i++) begin
                @(posedge clk); #1;
                vga_req = 1'b1; vga_x = '0; vga_y = LG'(5);
                vq.push_back(grid[5][0]);
                vga_issued++;
            end
            @(posedge clk); #1;
            vga_req = 1'b0;
        end
        wait_idle();
    endtask

    task automatic idle_hold(input string nm, input int over);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({nm, "_busy"}, int'(busy), 0);
            chk({nm, "_over"}, int'(round_over), over);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; vga_req = 1'b0;
        dir_p1 = 2'b00; dir_p2 = 2'b10; vga_x = '0; vga_y = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_p1_x", int'(p1_x), 8);
        chk("rst_p1_y", int'(p1_y), 16);
        chk("rst_p2_x", int'(p2_x), 23);
        chk("rst_p2_y", int'(p2_y), 16);
        chk("rst_crash", int'(crash), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_vga_rvalid", int'(vga_rvalid), 0);

        do_start(1'b0);
        vga_read(0, 5);
        vga_read(5, 5);
        vga_read(31, 20);
        vga_read(12, 30);

        // Start while READY is ignored.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        idle_hold("start_in_ready", 0);

        do_tick(2'b00, 2'b10, 0, 1'b1);   // p1 (9,16), p2 (22,16); extra tick dropped
        vga_read(8, 16);
        vga_read(23, 16);
        do_tick(2'b10, 2'b10, 0, 1'b0);   // 180 turn request for P1 ignored
        do_tick(2'b00, 2'b10, 20, 1'b0);  // stalled 20 cycles by VGA

        // Drive toward each other: head-on swap crashes both.
        for (int i = 0; i < 10 && !mover; i++) do_tick(2'b00, 2'b10, 0, 1'b0);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        idle_hold("tick_in_over", 1);

        // start and tick together in OVER: start wins.
        do_start(1'b1);

        // P2 turns up and then left along row 15; P1 runs right into the wall.
        do_tick(2'b00, 2'b01, 0, 1'b0);
        for (int i = 0; i < 30 && !mover; i++) do_tick(2'b00, 2'b10, 0, 1'b0);
        vga_read(30, 16);

        // Randomized rounds.
        for (int r = 0; r < 3; r++) begin
            if (!mover) break;
            do_start(1'b0);
            for (int t = 0; t < 40 && !mover; t++) begin
                do_tick(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, 1'b0);
                vga_read($urandom_range(0, GS-1), $urandom_range(0, GS-1));
            end
        end

        repeat (5) @(negedge clk);
        chk("step_queue_drained", sq.size(), 0);
        chk("vga_queue_drained", vq.size(), 0);
        chk("vga_rvalid_count", rv_seen, vga_issued);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
